// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared types and constants for the PS/2 keyboard receiver.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Number of data bits carried by one PS/2 frame
  localparam int PS2_DATA_BITS = 8;

  // Frame receiver states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } ps2_state_t;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones
  function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic                     parity);
    return ^{data, parity};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync.sv
`default_nettype none
// ============================================================================
// Module   : ps2_sync
// Brief    : 2-flop synchronizer for one PS/2 pad signal, with an optional
//            level filter that only accepts a new level after it has held
//            for FILTER_CYCLES consecutive clk cycles.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_sync #(
  parameter int FILTER_CYCLES = 8,
  parameter bit FILTER_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset_ni,
  input  logic in_i,
  output logic level_o
);

  logic [1:0] sync_q;

  // Two-stage synchronizer; idle bus level is high
  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], in_i};
    end
  end

  generate
    if (FILTER_EN) begin : g_filter
      localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
      logic [CNT_W-1:0] cnt_q;
      logic             level_q;

      // Count consecutive cycles the synchronized input disagrees with the
      // accepted level; adopt it on the FILTER_CYCLES-th cycle
      always_ff @(posedge clk) begin
        if (!reset_ni) begin
          cnt_q   <= '0;
          level_q <= 1'b1;
        end else if (sync_q[1] == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
          cnt_q   <= '0;
          level_q <= sync_q[1];
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign level_o = level_q;
    end else begin : g_bypass
      assign level_o = sync_q[1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_rx
// Brief    : PS/2 keyboard frame receiver. Filters the pad clock, samples data
//            on filtered falling edges, checks odd parity and the stop bit and
//            publishes good scan codes with a one-cycle strobe.
//            Optional frame timeout: define PS2_KBD_RX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FREQ_HZ       = 12000000,
  parameter int FILTER_CYCLES = 8,
  parameter int TIMEOUT_US    = 2000
) (
  input  logic       clk,
  input  logic       reset_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] code_o,
  output logic       strobe_o,
  output logic       err_o
);

  localparam int BIT_CNT_W = $clog2(PS2_DATA_BITS);

  // The timeout limit is derived in whole MHz, so slower clocks are unusable
  generate
    if (FREQ_HZ < 1000000 || TIMEOUT_US < 1) begin : g_cfg_check
      $error("ps2_kbd_rx: FREQ_HZ must be >= 1 MHz and TIMEOUT_US >= 1");
    end
  endgenerate

  logic clk_filt;
  logic data_sync;
  logic clk_filt_prev_q;
  logic fall;

  ps2_sync #(
    .FILTER_CYCLES(FILTER_CYCLES),
    .FILTER_EN    (1'b1)
  ) u_clk_sync (
    .clk     (clk),
    .reset_ni(reset_ni),
    .in_i    (ps2_clk_i),
    .level_o (clk_filt)
  );

  // Data is only sampled at a filtered clock edge, so it needs no filter
  ps2_sync #(
    .FILTER_CYCLES(FILTER_CYCLES),
    .FILTER_EN    (1'b0)
  ) u_data_sync (
    .clk     (clk),
    .reset_ni(reset_ni),
    .in_i    (ps2_data_i),
    .level_o (data_sync)
  );

  // Remember the previous filtered clock level for falling-edge detection
  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      clk_filt_prev_q <= 1'b1;
    end else begin
      clk_filt_prev_q <= clk_filt;
    end
  end

  assign fall = clk_filt_prev_q & ~clk_filt;

  ps2_state_t                 state_q;
  logic [BIT_CNT_W-1:0]       bit_cnt_q;
  logic [PS2_DATA_BITS-1:0]   shift_q;
  logic                       parity_q;
  logic [7:0]                 code_q;
  logic                       strobe_q;
  logic                       err_q;

`ifdef PS2_KBD_RX_TIMEOUT_EN
  localparam int TO_LIMIT = FREQ_HZ / 1000000 * TIMEOUT_US;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  logic [TO_W-1:0] to_cnt_q;
`endif

  // Frame FSM: advances only on filtered falling edges; pulses are registered
  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      code_q    <= 8'h00;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_KBD_RX_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      if (fall) begin
        case (state_q)
          S_IDLE: begin
            if (!data_sync) begin
              state_q   <= S_DATA;
              bit_cnt_q <= '0;
            end
          end
          S_DATA: begin
            shift_q <= {data_sync, shift_q[PS2_DATA_BITS-1:1]};
            if (bit_cnt_q == BIT_CNT_W'(PS2_DATA_BITS - 1)) begin
              state_q <= S_PARITY;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          S_PARITY: begin
            parity_q <= data_sync;
            state_q  <= S_STOP;
          end
          S_STOP: begin
            if (data_sync && ps2_parity_ok(shift_q, parity_q)) begin
              code_q   <= shift_q;
              strobe_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
`ifdef PS2_KBD_RX_TIMEOUT_EN
      else if (state_q != S_IDLE && to_cnt_q == TO_W'(TO_LIMIT)) begin
        // Host or keyboard stalled mid-frame: abandon it
        state_q <= S_IDLE;
        err_q   <= 1'b1;
      end

      if (fall || state_q == S_IDLE) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q != TO_W'(TO_LIMIT)) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
`endif
    end
  end

  assign code_o   = code_q;
  assign strobe_o = strobe_q;
  assign err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kbd_rx
// Brief    : Self-checking bench for ps2_kbd_rx. Drives PS/2 frames on the
//            pad pins and compares pulses and scan codes with a frame-level
//            model (odd parity, stop bit). Honours PS2_KBD_RX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_rx;

  localparam int FREQ_HZ = 1000000;
  localparam int FILT    = 8;
  localparam int TO_US   = 300;
  localparam int HP      = 20;   // PS/2 half period in clk cycles

  logic       clk = 1'b0;
  logic       reset_ni = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code_o;
  logic       strobe_o;
  logic       err_o;

  ps2_kbd_rx #(
    .FREQ_HZ      (FREQ_HZ),
    .FILTER_CYCLES(FILT),
    .TIMEOUT_US   (TO_US)
  ) dut (
    .clk       (clk),
    .reset_ni  (reset_ni),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .code_o    (code_o),
    .strobe_o  (strobe_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_strobe = 0;
  int n_err    = 0;
  int n_both   = 0;
  logic [7:0] seen_codes[$];
  logic [7:0] exp_code = 8'h00;

  // Pulse monitor sampled away from the active edge
  always @(negedge clk) begin
    if (strobe_o) begin
      n_strobe++;
      seen_codes.push_back(code_o);
    end
    if (err_o) n_err++;
    if (strobe_o && err_o) n_both++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the first n bits of an 11-bit frame (index 0 = start bit)
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_cyc(HP);
      ps2_clk = 1'b0;
      wait_cyc(HP);
      ps2_clk = 1'b1;
    end
    wait_cyc(HP);
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  // Reference rule: good when stop is 1 and ones(data)+parity is odd
  function automatic bit frame_good(input logic [7:0] d, input logic p, input logic s);
    return (s == 1'b1) && ((($countones(d) + int'(p)) % 2) == 1);
  endfunction

  task automatic test_reset();
    reset_ni = 1'b0;
    wait_cyc(4);
    n_checks++;
    if (code_o !== 8'h00) $display("FAIL reset_code: got %h want 00", code_o); else n_pass++;
    n_checks++;
    if (strobe_o !== 1'b0 || err_o !== 1'b0)
      $display("FAIL reset_pulses: got strobe=%b err=%b want 0 0", strobe_o, err_o);
    else n_pass++;
    reset_ni = 1'b1;
    wait_cyc(HP);
    exp_code = 8'h00;
  endtask

  task automatic test_basic();
    int s0, e0;
    s0 = n_strobe; e0 = n_err;
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11);
    exp_code = 8'h1C;
    n_checks++;
    if (n_strobe - s0 !== 1) $display("FAIL basic_strobe: got %0d pulses want 1", n_strobe - s0); else n_pass++;
    n_checks++;
    if (n_err - e0 !== 0) $display("FAIL basic_err: got %0d pulses want 0", n_err - e0); else n_pass++;
    n_checks++;
    if (code_o !== exp_code) $display("FAIL basic_code: got %h want %h", code_o, exp_code); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int e0;
    e0 = n_err;
    seen_codes.delete();
    send_bits(mk_frame(8'hF0, 1'b1, 1'b1), 11);
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11);
    exp_code = 8'h1C;
    n_checks++;
    if (seen_codes.size() != 2)
      $display("FAIL b2b_count: got %0d strobes want 2", seen_codes.size());
    else if (seen_codes[0] !== 8'hF0 || seen_codes[1] !== 8'h1C)
      $display("FAIL b2b_codes: got %h,%h want f0,1c", seen_codes[0], seen_codes[1]);
    else n_pass++;
    n_checks++;
    if (n_err - e0 !== 0) $display("FAIL b2b_err: got %0d pulses want 0", n_err - e0); else n_pass++;
  endtask

  task automatic test_bad_frames();
    int s0, e0;
    s0 = n_strobe; e0 = n_err;
    send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11);
    n_checks++;
    if (n_err - e0 !== 1 || n_strobe - s0 !== 0)
      $display("FAIL bad_parity: got err=%0d strobe=%0d want 1 0", n_err - e0, n_strobe - s0);
    else n_pass++;
    n_checks++;
    if (code_o !== exp_code) $display("FAIL bad_parity_code: got %h want %h", code_o, exp_code); else n_pass++;
    s0 = n_strobe; e0 = n_err;
    send_bits(mk_frame(8'h5A, 1'b1, 1'b0), 11);
    n_checks++;
    if (n_err - e0 !== 1 || n_strobe - s0 !== 0)
      $display("FAIL bad_stop: got err=%0d strobe=%0d want 1 0", n_err - e0, n_strobe - s0);
    else n_pass++;
    n_checks++;
    if (code_o !== exp_code) $display("FAIL bad_stop_code: got %h want %h", code_o, exp_code); else n_pass++;
  endtask

  task automatic test_glitch();
    int s0, e0;
    s0 = n_strobe; e0 = n_err;
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    wait_cyc(2);
    ps2_clk  = 1'b1;
    wait_cyc(3 * HP);
    ps2_data = 1'b1;
    n_checks++;
    if (n_strobe - s0 !== 0 || n_err - e0 !== 0)
      $display("FAIL glitch_pulses: got strobe=%0d err=%0d want 0 0", n_strobe - s0, n_err - e0);
    else n_pass++;
    // A glitch taken as a start bit would misalign this frame
    send_bits(mk_frame(8'h5A, 1'b1, 1'b1), 11);
    exp_code = 8'h5A;
    n_checks++;
    if (n_strobe - s0 !== 1 || code_o !== exp_code)
      $display("FAIL glitch_next: got strobes=%0d code=%h want 1 %h", n_strobe - s0, code_o, exp_code);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int s0, e0;
    s0 = n_strobe; e0 = n_err;
    send_bits(mk_frame(8'h33, 1'b1, 1'b1), 5);
    wait_cyc(FREQ_HZ / 1000000 * TO_US + 200);
`ifdef PS2_KBD_RX_TIMEOUT_EN
    n_checks++;
    if (n_err - e0 !== 1 || n_strobe - s0 !== 0)
      $display("FAIL timeout_err: got err=%0d strobe=%0d want 1 0", n_err - e0, n_strobe - s0);
    else n_pass++;
    s0 = n_strobe;
    send_bits(mk_frame(8'h5A, 1'b1, 1'b1), 11);
    exp_code = 8'h5A;
    n_checks++;
    if (n_strobe - s0 !== 1 || code_o !== exp_code)
      $display("FAIL timeout_next: got strobes=%0d code=%h want 1 %h", n_strobe - s0, code_o, exp_code);
    else n_pass++;
`else
    n_checks++;
    if (n_err - e0 !== 0 || n_strobe - s0 !== 0)
      $display("FAIL stall_pulses: got err=%0d strobe=%0d want 0 0", n_err - e0, n_strobe - s0);
    else n_pass++;
    // Clear the stalled frame
    reset_ni = 1'b0;
    wait_cyc(1);
    reset_ni = 1'b1;
    wait_cyc(HP);
    exp_code = 8'h00;
`endif
  endtask

  task automatic test_reset_mid_frame();
    int s0, e0;
    s0 = n_strobe; e0 = n_err;
    send_bits(mk_frame(8'hA7, 1'b1, 1'b1), 4);
    reset_ni = 1'b0;
    wait_cyc(1);
    reset_ni = 1'b1;
    exp_code = 8'h00;
    wait_cyc(3 * HP);
    n_checks++;
    if (n_strobe - s0 !== 0 || n_err - e0 !== 0)
      $display("FAIL midreset_pulses: got strobe=%0d err=%0d want 0 0", n_strobe - s0, n_err - e0);
    else n_pass++;
    n_checks++;
    if (code_o !== exp_code) $display("FAIL midreset_code: got %h want %h", code_o, exp_code); else n_pass++;
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11);
    exp_code = 8'h1C;
    n_checks++;
    if (n_strobe - s0 !== 1 || code_o !== exp_code)
      $display("FAIL midreset_next: got strobes=%0d code=%h want 1 %h", n_strobe - s0, code_o, exp_code);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       p, s;
    bit         good;
    int         s0, e0;
    for (int k = 0; k < 16; k++) begin
      d = 8'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 7) != 0);
      good = frame_good(d, p, s);
      if (good) exp_code = d;
      s0 = n_strobe; e0 = n_err;
      send_bits(mk_frame(d, p, s), 11);
      n_checks++;
      if (n_strobe - s0 !== (good ? 1 : 0) || n_err - e0 !== (good ? 0 : 1) || code_o !== exp_code)
        $display("FAIL random[%0d] d=%h p=%b s=%b: got strobe=%0d err=%0d code=%h want %0d %0d %h",
                 k, d, p, s, n_strobe - s0, n_err - e0, code_o, good ? 1 : 0, good ? 0 : 1, exp_code);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_bad_frames();
    test_glitch();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    n_checks++;
    if (n_both !== 0) $display("FAIL overlap: got %0d cycles with strobe and err want 0", n_both); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 Parameter FREQ_HZ, default 12000000: system clock frequency in Hz.
REQ-002 Parameter FILTER_CYCLES, default 8: cycles ps2_clk must hold a level before that level is accepted.
REQ-003 Parameter TIMEOUT_US, default 2000: maximum time allowed between bit edges within a frame.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset_ni  input  1  reset, synchronous and active-low.
REQ-006 ps2_clk_i  input  1  raw PS/2 clock from the pad; asynchronous to clk.
REQ-007 ps2_data_i  input  1  raw PS/2 data from the pad; asynchronous to clk.
REQ-008 code_o  output  8  last correctly received scan code; holds its value between frames.
REQ-009 strobe_o  output  1  one-cycle pulse meaning code_o has just been updated with a good frame.
REQ-010 err_o  output  1  one-cycle pulse meaning a frame was rejected.

Function
REQ-011 ps2_clk_i and ps2_data_i SHALL each pass through a 2-flop synchronizer.
REQ-012 Filtered clock: the synchronized clock SHALL be accepted as the new filtered level only after it holds for FILTER_CYCLES consecutive cycles; the filtered level resets to 1.
REQ-013 Falling edge: a change of the filtered level from 1 to 0; on that cycle the synchronized data SHALL be sampled.
REQ-014 FSM states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: sampled 0 goes to DATA with the bit counter cleared; sampled 1 stays in IDLE with no pulse.
REQ-016 DATA: shift the bit in LSB-first; after the 8th bit, go to PARITY.
REQ-017 PARITY: store the bit; go to STOP.
REQ-018 STOP: the frame is good if the stop bit is 1 and XOR(data, parity) = 1 (odd parity).
REQ-019 Good frame: code_o gets the data, strobe_o = 1, err_o = 0, and the FSM returns to IDLE.
REQ-020 Bad frame: err_o = 1, strobe_o = 0, code_o unchanged, and the FSM returns to IDLE.
REQ-021 Latency: strobe_o/err_o SHALL assert on the cycle after the stop-bit falling edge, for exactly 1 cycle.
REQ-022 strobe_o and err_o SHALL never be high in the same cycle.
REQ-023 Falling edges only advance the FSM; rising edges and filtered-out glitches SHALL have no effect.
REQ-024 Back-to-back frames SHALL be accepted, including a start edge on the cycle the previous strobe is high.

Reset
REQ-025 With reset_ni = 0 at a clk edge: FSM = IDLE, bit counter = 0, shift register = 0, code_o = 0x00, strobe_o = 0, err_o = 0, filtered level = 1, synchronizers = 1, timeout counter = 0.
REQ-026 A reset mid-frame SHALL discard the partial frame without any strobe_o or err_o pulse.

Configuration
REQ-027 Macro PS2_KBD_RX_TIMEOUT_EN defined: a counter of width $clog2(FREQ_HZ/1000000*TIMEOUT_US+1) runs while not in IDLE and clears on every falling edge.
REQ-028 With the macro defined: when the counter reaches FREQ_HZ/1000000*TIMEOUT_US, the FSM goes to IDLE and err_o pulses for 1 cycle.
REQ-029 Macro undefined: no timeout counter; a stalled frame stays in its current state until the next falling edge or reset.

Structure
REQ-030 Package ps2_pkg SHALL hold the FSM state enum (ps2_state_t) and constant PS2_DATA_BITS = 8.
REQ-031 Sub-module ps2_sync SHALL hold the 2-flop synchronizer and the FILTER_CYCLES filter, with one instance for clock and data; everything else stays flat.

Verification
REQ-032 Frame 0x1C, parity 0, stop 1 -> strobe_o one cycle, code_o = 0x1C, err_o never high.
REQ-033 Frames 0xF0 (parity 1) then 0x1C back-to-back -> two strobes, code_o = 0xF0 then 0x1C.
REQ-034 Frame 0x1C with parity 1 -> err_o one cycle, no strobe_o, code_o keeps its prior value; frame 0x5A with stop bit 0 -> same response.
REQ-035 2-cycle low glitch on ps2_clk_i in IDLE with FILTER_CYCLES = 8 -> no state change, no pulses.
REQ-036 With PS2_KBD_RX_TIMEOUT_EN defined, clock stops after 5 bits -> err_o once the timeout count is reached, then frame 0x5A (parity 1) -> strobe_o with code_o = 0x5A.
REQ-037 reset_ni low for 1 cycle after 4 bits of a frame -> no pulses, code_o = 0x00; next frame 0x1C received correctly.
